alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle execute stage for the 8-bit simple core. It accepts one decoded instruction at a time over a valid/ready handshake and reads the named register through the register file's single address port. It combines that register with the accumulator (register 0), sets carry and zero flags, and writes the result back through the same port. It sits directly upstream of the register file and drives its ADDR, WDATA and WEN inputs.

## Interface
- WIDTH, 8, datapath width; all register, operand and result widths.
- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- IVALID  in  1  instruction valid from decode.
- IREADY  out  1  ready to accept; forced to 0 while RSTN is low.
- IOP  in  3  opcode: 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 ADDC.
- IADDR  in  2  operand register index (0–3).
- RF_ADDR  out  2  register file address.
- RF_RDATA  in  WIDTH  register file read data, combinational from RF_ADDR.
- RF0DATA  in  WIDTH  accumulator (register 0) value, always visible.
- RF_WDATA  out  WIDTH  write-back data.
- RF_WEN  out  1  write enable; pulses for exactly one cycle per writing instruction.
- CARRY  out  1  carry/borrow flag.
- ZERO  out  1  zero flag.
- BUSY  out  1  high whenever the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE → READ → EXEC → WRITE → IDLE. All states are registered. State encoding lives in the package.
- **IDLE:**
  - IREADY=1 (if RSTN is high), RF_ADDR=0, RF_WEN=0.
  - When IVALID&&IREADY at an edge, latch IOP and IADDR and go to READ.
- **READ:** RF_ADDR = latched IADDR. At the edge, capture RF_RDATA into opnd and RF0DATA into acc.
- **EXEC:** compute the result and next flags from opnd/acc. Register them at the edge.
- **WRITE:**
  - RF_ADDR = destination (0 for every op except STORE, which uses the latched IADDR).
  - RF_WDATA = registered result.
  - RF_WEN=1, except for a no-write op.
- **Per-op behaviour:**
  - LOAD: r0 ← opnd. Z updated, C unchanged.
  - STORE: r[IADDR] ← acc. Flags unchanged.
  - ADD: r0 ← acc+opnd. C = bit WIDTH of the (WIDTH+1)-bit sum. Z = (result==0).
  - SUB: r0 ← acc−opnd, modulo 2^WIDTH. C = borrow (1 iff acc<opnd). Z = (result==0).
  - AND, OR, XOR: r0 ← acc op opnd. Z updated, C cleared.
  - ADDC: as ADD, with CARRY as an additional carry-in.
- **STORE to index 1:** the register file ignores writes to the input port. The block still pulses RF_WEN and takes no special action.
- **LOAD/ALU with IADDR=0:** the operand is the accumulator itself; no special case.
- **IVALID outside IDLE:** ignored. Decode must hold the instruction until the handshake completes.

## Timing
- **Reset values:** IREADY=0 during reset, BUSY=0, RF_WEN=0, RF_ADDR=0, RF_WDATA=0, CARRY=0, ZERO=0, state=IDLE.
- **Mid-instruction reset:** reset asserted in any state aborts the instruction. No RF_WEN pulse follows, and flags are cleared.
- **Cycle numbering** (accept edge = edge 0):
  - Cycle 1: READ.
  - Cycle 2: EXEC.
  - Cycle 3: WRITE, RF_WEN high. The register commits at edge 3.
  - Cycle 4: IDLE, IREADY high.
- **Throughput:** one instruction per 4 cycles, with no overlap.
- **Flag update timing:** CARRY/ZERO update at edge 2, the end of EXEC. They are visible from cycle 3.
- **Back-to-back dependency:** an instruction accepted at edge 4 reads r0 in cycle 5 and sees the value committed at edge 3, so no forwarding is needed.
- **Outputs:** all outputs are registered or decoded from registered state only. No combinational path from IVALID to RF_WEN.

## Configuration
- **ALU_SEQ_ADDC_EN defined:** op 7 is ADDC as described above.
- **ALU_SEQ_ADDC_EN undefined:** op 7 is a NOP.
  - Still traverses all four states.
  - RF_WEN stays 0 in WRITE.
  - Flags unchanged.

## Structure
- **Package alu_seq_pkg:** opcode localparams (OP_LOAD … OP_ADDC) and FSM state encoding (ST_IDLE, ST_READ, ST_EXEC, ST_WRITE).
- **Sub-module alu_seq_alu:** purely combinational.
  - Inputs: op, acc, opnd, carry_in.
  - Outputs: result, carry_out, zero, wen.
  - Instantiated once inside alu_seq, which holds the FSM, latches and output registers.

## Test plan
- **Reset:** after reset, r0=0x00. LOAD r1 with RF1DATA=0x5A → RF_WEN pulses in cycle 3 with RF_ADDR=0, RF_WDATA=0x5A; ZERO=0.
- **ADD overflow:** acc=0xF0, r2=0x20, ADD 2 → result 0x10, CARRY=1, ZERO=0. Then ADDC 2 (ADDC_EN) → 0x31, CARRY=0.
- **SUB to zero:** acc=0x33, r3=0x33, SUB 3 → 0x00, ZERO=1, CARRY=0. Then SUB 3 again with acc=0x00 → 0xCD, CARRY=1.
- **STORE:** acc=0xA5, STORE 3 → RF_ADDR=3, RF_WDATA=0xA5, and r3 reads 0xA5 afterwards. Flags hold their prior values.
- **Handshake:** IVALID held high continuously → IREADY high only every 4th cycle. Exactly one RF_WEN pulse per accepted op.
- **Reset during EXEC:** RSTN low in cycle 2 → no RF_WEN, flags 0, IREADY=0 until the first cycle after RSTN rises.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM encoding and flag helper for alu_seq
// Op 7 is ADDC when ALU_SEQ_ADDC_EN is defined, otherwise a NOP.
package alu_seq_pkg;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_OR    = 3'd5;
  localparam logic [2:0] OP_XOR   = 3'd6;
  localparam logic [2:0] OP_ADDC  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // STORE (and the NOP form of op 7) leave ZERO untouched.
  function automatic logic op_updates_zero(input logic [2:0] op);
    if (op == OP_STORE) return 1'b0;
`ifndef ALU_SEQ_ADDC_EN
    if (op == OP_ADDC) return 1'b0;
`endif
    return 1'b1;
  endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// rtl/alu_seq_alu.sv - combinational ALU for alu_seq
// Op 7 is ADDC when ALU_SEQ_ADDC_EN is defined, otherwise a non-writing NOP.
module alu_seq_alu
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             wen
);

  logic [WIDTH:0] sum;

  // carry_out defaults to carry_in so ops that keep C simply pass it through.
  always_comb begin
    result    = '0;
    carry_out = carry_in;
    wen       = 1'b1;
    sum       = '0;
    case (op)
      OP_LOAD:  result = opnd;
      OP_STORE: result = acc;
      OP_ADD: begin
        sum       = {1'b0, acc} + {1'b0, opnd};
        result    = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
      end
      OP_SUB: begin
        sum       = {1'b0, acc} - {1'b0, opnd};
        result    = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
      end
      OP_AND: begin result = acc & opnd; carry_out = 1'b0; end
      OP_OR:  begin result = acc | opnd; carry_out = 1'b0; end
      OP_XOR: begin result = acc ^ opnd; carry_out = 1'b0; end
      default: begin
`ifdef ALU_SEQ_ADDC_EN
        sum       = {1'b0, acc} + {1'b0, opnd} + {{WIDTH{1'b0}}, carry_in};
        result    = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
`else
        wen       = 1'b0;
`endif
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - four-state execute stage driving the register file port
// Op 7 is ADDC when ALU_SEQ_ADDC_EN is defined, otherwise a NOP.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             IVALID,
  output logic             IREADY,
  input  logic [2:0]       IOP,
  input  logic [1:0]       IADDR,
  output logic [1:0]       RF_ADDR,
  input  logic [WIDTH-1:0] RF_RDATA,
  input  logic [WIDTH-1:0] RF0DATA,
  output logic [WIDTH-1:0] RF_WDATA,
  output logic             RF_WEN,
  output logic             CARRY,
  output logic             ZERO,
  output logic             BUSY
);

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [1:0]       addr_q;
  logic [WIDTH-1:0] opnd, acc, res_q;
  logic             wen_q, carry_q, zero_q;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry, alu_zero, alu_wen;

  alu_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op        (op_q),
    .acc       (acc),
    .opnd      (opnd),
    .carry_in  (carry_q),
    .result    (alu_result),
    .carry_out (alu_carry),
    .zero      (alu_zero),
    .wen       (alu_wen)
  );

  always_ff @(posedge CLK) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (IVALID) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_WRITE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    IREADY  = 1'b0;
    BUSY    = 1'b1;
    RF_ADDR = 2'd0;
    RF_WEN  = 1'b0;
    case (state)
      ST_IDLE: begin
        IREADY = RSTN;
        BUSY   = 1'b0;
      end
      ST_READ: RF_ADDR = addr_q;
      ST_WRITE: begin
        RF_ADDR = (op_q == OP_STORE) ? addr_q : 2'd0;
        RF_WEN  = wen_q;
      end
      default: ;
    endcase
  end

  // Operand capture, then result and flags, all on the state-advancing edge.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      op_q    <= OP_LOAD;
      addr_q  <= '0;
      opnd    <= '0;
      acc     <= '0;
      res_q   <= '0;
      wen_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (IVALID) begin
          op_q   <= IOP;
          addr_q <= IADDR;
        end
        ST_READ: begin
          opnd <= RF_RDATA;
          acc  <= RF0DATA;
        end
        ST_EXEC: begin
          res_q   <= alu_result;
          wen_q   <= alu_wen;
          carry_q <= alu_carry;
          if (op_updates_zero(op_q)) zero_q <= alu_zero;
        end
        default: ;
      endcase
    end
  end

  assign RF_WDATA = res_q;
  assign CARRY    = carry_q;
  assign ZERO     = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed-vector bench for alu_seq with a small register file model
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       IVALID;
  logic       IREADY;
  logic [2:0] IOP;
  logic [1:0] IADDR;
  logic [1:0] RF_ADDR;
  logic [7:0] RF_RDATA;
  logic [7:0] RF0DATA;
  logic [7:0] RF_WDATA;
  logic       RF_WEN;
  logic       CARRY;
  logic       ZERO;
  logic       BUSY;

  logic [7:0] regs [0:3];
  logic [7:0] rf1;
  logic       rf_clr;
  int         n_vec = 0;
  int         n_miss = 0;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .IVALID(IVALID), .IREADY(IREADY), .IOP(IOP), .IADDR(IADDR),
    .RF_ADDR(RF_ADDR), .RF_RDATA(RF_RDATA), .RF0DATA(RF0DATA), .RF_WDATA(RF_WDATA),
    .RF_WEN(RF_WEN), .CARRY(CARRY), .ZERO(ZERO), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Register file: r1 is the input port and ignores writes.
  always @(posedge CLK) begin
    if (rf_clr) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (RF_WEN && RF_ADDR != 2'd1) begin
      regs[RF_ADDR] <= RF_WDATA;
    end
  end

  always_comb begin
    RF_RDATA = (RF_ADDR == 2'd1) ? rf1 : regs[RF_ADDR];
    RF0DATA  = regs[0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction from IDLE and check every cycle through the return to IDLE.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [1:0] a,
                       input logic ewen, input logic [1:0] eaddr, input logic [7:0] edata,
                       input logic ec, input logic ez);
    int n;
    n = 0;
    while (!IREADY && n < 16) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 16) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    IVALID = 1'b1;
    IOP    = op;
    IADDR  = a;
    @(negedge CLK);
    IVALID = 1'b0;
    check({tag, "_c1_busy"}, BUSY, 1'b1);
    check({tag, "_c1_addr"}, RF_ADDR, a);
    check({tag, "_c1_wen"}, RF_WEN, 1'b0);
    @(negedge CLK);
    check({tag, "_c2_wen"}, RF_WEN, 1'b0);
    @(negedge CLK);
    check({tag, "_c3_wen"}, RF_WEN, ewen);
    if (ewen) begin
      check({tag, "_c3_addr"}, RF_ADDR, eaddr);
      check({tag, "_c3_wdata"}, RF_WDATA, edata);
    end
    check({tag, "_carry"}, CARRY, ec);
    check({tag, "_zero"}, ZERO, ez);
    @(negedge CLK);
    check({tag, "_c4_ready"}, IREADY, 1'b1);
    check({tag, "_c4_wen"}, RF_WEN, 1'b0);
  endtask

  initial begin
    int rdy;
    int pulses;
    RSTN = 1'b0; rf_clr = 1'b1; IVALID = 1'b0; IOP = OP_LOAD; IADDR = 2'd0; rf1 = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_iready", IREADY, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_wen", RF_WEN, 1'b0);
    check("rst_addr", RF_ADDR, 2'd0);
    check("rst_wdata", RF_WDATA, 8'h00);
    check("rst_carry", CARRY, 1'b0);
    check("rst_zero", ZERO, 1'b0);
    RSTN = 1'b1; rf_clr = 1'b0;
    #1;
    check("rst_release_iready", IREADY, 1'b1);
    @(negedge CLK);

    rf1 = 8'h5A; do_op("load1", OP_LOAD, 2'd1, 1'b1, 2'd0, 8'h5A, 1'b0, 1'b0);

    rf1 = 8'h20; do_op("ld20", OP_LOAD, 2'd1, 1'b1, 2'd0, 8'h20, 1'b0, 1'b0);
    do_op("st2", OP_STORE, 2'd2, 1'b1, 2'd2, 8'h20, 1'b0, 1'b0);
    rf1 = 8'hF0; do_op("ldf0", OP_LOAD, 2'd1, 1'b1, 2'd0, 8'hF0, 1'b0, 1'b0);
    do_op("add_ovf", OP_ADD, 2'd2, 1'b1, 2'd0, 8'h10, 1'b1, 1'b0);
`ifdef ALU_SEQ_ADDC_EN
    do_op("addc", OP_ADDC, 2'd2, 1'b1, 2'd0, 8'h31, 1'b0, 1'b0);
`else
    do_op("nop7", OP_ADDC, 2'd2, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
`endif

    rf1 = 8'h33; do_op("ld33", OP_LOAD, 2'd1, 1'b1, 2'd0, 8'h33, CARRY, 1'b0);
    do_op("st3", OP_STORE, 2'd3, 1'b1, 2'd3, 8'h33, CARRY, 1'b0);
    do_op("sub_zero", OP_SUB, 2'd3, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1);
    do_op("sub_borrow", OP_SUB, 2'd3, 1'b1, 2'd0, 8'hCD, 1'b1, 1'b0);

    rf1 = 8'hA5; do_op("lda5", OP_LOAD, 2'd1, 1'b1, 2'd0, 8'hA5, 1'b1, 1'b0);
    do_op("store3", OP_STORE, 2'd3, 1'b1, 2'd3, 8'hA5, 1'b1, 1'b0);
    do_op("load3", OP_LOAD, 2'd3, 1'b1, 2'd0, 8'hA5, 1'b1, 1'b0);

    rf1 = 8'h0F; do_op("and", OP_AND, 2'd1, 1'b1, 2'd0, 8'h05, 1'b0, 1'b0);
    rf1 = 8'hF0; do_op("or", OP_OR, 2'd1, 1'b1, 2'd0, 8'hF5, 1'b0, 1'b0);
    rf1 = 8'hF5; do_op("xor", OP_XOR, 2'd1, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1);
    do_op("store1", OP_STORE, 2'd1, 1'b1, 2'd1, 8'h00, 1'b0, 1'b1);
    do_op("load0", OP_LOAD, 2'd0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1);

    // IVALID held high: one accept every fourth cycle, one write each.
    rf1 = 8'h11; IOP = OP_LOAD; IADDR = 2'd1; IVALID = 1'b1;
    rdy = 0; pulses = 0;
    for (int i = 0; i < 16; i++) begin
      check("hs_iready", IREADY, (i % 4) == 0);
      if (IREADY) rdy++;
      if (RF_WEN) pulses++;
      @(negedge CLK);
    end
    IVALID = 1'b0;
    check("hs_accepts", rdy, 4);
    check("hs_pulses", pulses, 4);
    check("hs_r0", regs[0], 8'h11);

    // Abort an ADD with reset during EXEC.
    rf1 = 8'h00; do_op("ld00", OP_LOAD, 2'd1, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1);
    rf1 = 8'h77; IOP = OP_ADD; IADDR = 2'd1; IVALID = 1'b1;
    @(negedge CLK);
    IVALID = 1'b0;
    @(negedge CLK);
    check("mid_in_exec", BUSY, 1'b1);
    RSTN = 1'b0;
    @(negedge CLK);
    check("mid_iready", IREADY, 1'b0);
    check("mid_wen", RF_WEN, 1'b0);
    check("mid_busy", BUSY, 1'b0);
    check("mid_carry", CARRY, 1'b0);
    check("mid_zero", ZERO, 1'b0);
    RSTN = 1'b1;
    #1;
    check("mid_release_iready", IREADY, 1'b1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (RF_WEN) pulses++;
    end
    check("mid_no_write", pulses, 0);
    check("mid_r0_kept", regs[0], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
